ins_dispatch_queue: RTL

//  Parametrised multi-wide, in-order instruction queue between decode and top_issue_stage.

---
 rtl/ins_dispatch_queue.sv | 120 ++++++++++++
 1 files changed

// File: rtl/ins_dispatch_queue.sv
// In-order multi-wide dispatch queue between decode and issue.
// Supports per-cycle take, branch-tag flush of the youngest speculative tail, and enqueue.
module ins_dispatch_queue #(
  parameter int DES       = 4,
  parameter int SOURCE1   = 4,
  parameter int SOURCE2   = 4,
  parameter int IMMEDIATE = 4,
  parameter int BRANCH_ID = 3,
  parameter int DEPTH     = 8,
  parameter int ENQ_W     = 2,
  parameter int DEQ_W     = 2,
  localparam int ENTRY_W  = 4 + DES + SOURCE1 + SOURCE2 + BRANCH_ID + 1 + IMMEDIATE,
  localparam int TW       = $clog2(DEQ_W + 1),
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ENQ_W-1:0]         enq_valid,
  input  logic [ENQ_W*ENTRY_W-1:0] enq_data,
  output logic                     enq_ready,
  output logic [DEQ_W-1:0]         deq_valid,
  output logic [DEQ_W*ENTRY_W-1:0] deq_data,
  input  logic [TW-1:0]            deq_take,
  input  logic                     flush,
  input  logic [BRANCH_ID-1:0]     flush_bid,
  output logic [CW-1:0]            count,
  output logic                     full,
  output logic                     empty,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      head_q, tail_q, head_n, tail_n, head_mid, idx;
  logic [CW-1:0]      count_q, count_n, cnt_mid, take_eff, hit_off, n_enq;
  logic               err_q, err_n, take_err, enq_err, do_enq, hit, contig;

  always_comb begin
    take_eff = CW'(deq_take);
    take_err = 1'b0;
    if (take_eff > count_q) begin
      take_err = 1'b1;
      take_eff = count_q;
    end
    head_mid = head_q + AW'(take_eff);
    cnt_mid  = count_q - take_eff;

    // Flush scan runs over what survives this cycle's take, oldest first.
    hit     = 1'b0;
    hit_off = '0;
    idx     = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head_mid + AW'(k);
      if (!hit && CW'(k) < cnt_mid && mem[idx][IMMEDIATE] &&
          mem[idx][IMMEDIATE+1 +: BRANCH_ID] == flush_bid) begin
        hit     = 1'b1;
        hit_off = CW'(k);
      end
    end

    n_enq = '0;
    for (int unsigned i = 0; i < ENQ_W; i++)
      n_enq = n_enq + CW'(enq_valid[i]);
    contig    = ((enq_valid + ENQ_W'(1)) & enq_valid) == '0;
    enq_ready = (CW'(DEPTH) - count_q) >= CW'(ENQ_W);

    enq_err = !flush && (enq_valid != '0) && (!contig || !enq_ready);
    do_enq  = !flush && (enq_valid != '0) && contig && enq_ready;

    head_n  = head_mid;
    tail_n  = tail_q;
    count_n = cnt_mid;
    if (flush && hit) begin
      tail_n  = head_mid + AW'(hit_off);
      count_n = hit_off;
    end else if (do_enq) begin
      tail_n  = tail_q + AW'(n_enq);
      count_n = cnt_mid + n_enq;
    end
    err_n = err_q | take_err | enq_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_n;
      tail_q  <= tail_n;
      count_q <= count_n;
      err_q   <= err_n;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < ENQ_W; i++)
      if (do_enq && CW'(i) < n_enq)
        mem[tail_q + AW'(i)] <= enq_data[i*ENTRY_W +: ENTRY_W];
  end

  // Slots beyond count read as zero so stale storage never leaks after reset.
  always_comb begin
    deq_valid = '0;
    deq_data  = '0;
    for (int unsigned i = 0; i < DEQ_W; i++) begin
      deq_valid[i] = count_q > CW'(i);
      if (deq_valid[i])
        deq_data[i*ENTRY_W +: ENTRY_W] = mem[head_q + AW'(i)];
    end
  end

  assign count = count_q;
  assign full  = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign err   = err_q;

endmodule
